// File: rtl/pwm_mc_pkg.sv
// Shared defaults for the multi-channel PWM block.
// Holds the default channel count, widths and the active-top reset constant.
package pwm_mc_pkg;

   localparam int NUM_CH_DEF = 16;
   localparam int CNT_W_DEF  = 8;
   localparam int PRE_W_DEF  = 8;

   // Truncated to CNT_W at the point of use, so it means "all ones" for any width.
   localparam logic [31:0] TOP_RST_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, period counter, wrap detection and the registered period_start pulse
// shared by every channel of pwm_multichannel.
module pwm_timebase
   import pwm_mc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PRE_W = PRE_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PRE_W-1:0] prescale_i,
   input  logic [CNT_W-1:0] top_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             wrap_o,
   output logic             period_start_o
);

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             period_start_q;
   logic             tick;
   logic             wrap;

   // Equality (not >=) lets a pre_cnt above a freshly lowered prescale run out and wrap.
   always_comb begin
      tick      = (pre_cnt_q == prescale_i);
      wrap      = tick && (cnt_q >= top_i);
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      cnt_d     = cnt_q;
      if (wrap) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt_q      <= '0;
         cnt_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         pre_cnt_q      <= pre_cnt_d;
         cnt_q          <= cnt_d;
         period_start_q <= wrap;
      end
   end

   assign cnt_o          = cnt_q;
   assign wrap_o         = wrap;
   assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with per-channel duty registers, programmable period and prescaler.
// Define PWM_SHADOW_EN to double-buffer duty and top so changes land on period boundaries.
module pwm_multichannel
   import pwm_mc_pkg::*;
#(
   parameter  int NUM_CH = NUM_CH_DEF,
   parameter  int CNT_W  = CNT_W_DEF,
   parameter  int PRE_W  = PRE_W_DEF,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en_out,
   input  logic [NUM_CH-1:0] en_pwm,
   input  logic              duty_we,
   input  logic [SEL_W-1:0]  duty_sel,
   input  logic [CNT_W-1:0]  duty_wdata,
   input  logic [CNT_W-1:0]  period_top,
   input  logic [PRE_W-1:0]  prescale,
   output logic [NUM_CH-1:0] out,
   output logic              period_start
);

   localparam logic [SEL_W:0] NUM_CH_L = NUM_CH[SEL_W:0];

   logic [CNT_W-1:0]  act_q [NUM_CH];
   logic [CNT_W-1:0]  act_d [NUM_CH];
   logic [NUM_CH-1:0] out_q, out_d;
   logic [CNT_W-1:0]  top_act;
   logic [CNT_W-1:0]  cnt;
   logic              wrap;
   logic              wr_en;

   // duty_we is a single-cycle strobe with no back-pressure; out-of-range selects are dropped.
   assign wr_en = duty_we && ({1'b0, duty_sel} < NUM_CH_L);

   pwm_timebase #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
   ) u_timebase (
      .clk            (clk),
      .rst_n          (rst_n),
      .prescale_i     (prescale),
      .top_i          (top_act),
      .cnt_o          (cnt),
      .wrap_o         (wrap),
      .period_start_o (period_start)
   );

`ifdef PWM_SHADOW_EN
   logic [CNT_W-1:0] pend_q [NUM_CH];
   logic [CNT_W-1:0] pend_d [NUM_CH];
   logic [CNT_W-1:0] top_q, top_d;

   // Active load takes pend_d, so a write coinciding with the wrap is forwarded.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pend_d[i] = pend_q[i];
         if (wr_en && (duty_sel == SEL_W'(i))) begin
            pend_d[i] = duty_wdata;
         end
         act_d[i] = wrap ? pend_d[i] : act_q[i];
      end
      top_d = wrap ? period_top : top_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            pend_q[i] <= '0;
         end
         top_q <= TOP_RST_ONES[CNT_W-1:0];
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            pend_q[i] <= pend_d[i];
         end
         top_q <= top_d;
      end
   end

   assign top_act = top_q;
`else
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         act_d[i] = act_q[i];
         if (wr_en && (duty_sel == SEL_W'(i))) begin
            act_d[i] = duty_wdata;
         end
      end
   end

   assign top_act = period_top;
`endif

   // A duty above top can never be reached by cnt, so it means 100%.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         out_d[i] = 1'b0;
         if (!en_out[i]) begin
            out_d[i] = 1'b0;
         end else if (!en_pwm[i]) begin
            out_d[i] = 1'b1;
         end else if (act_q[i] == '0) begin
            out_d[i] = 1'b0;
         end else if (act_q[i] > top_act) begin
            out_d[i] = 1'b1;
         end else begin
            out_d[i] = (cnt < act_q[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            act_q[i] <= '0;
         end
         out_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            act_q[i] <= act_d[i];
         end
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel (NUM_CH=16, CNT_W=8); expectations are hand-derived
// cycle counts, with PWM_SHADOW_EN-dependent steps selected by the same macro.
module tb_pwm_multichannel;

   logic        clk;
   logic        rst_n;
   logic [15:0] en_out;
   logic [15:0] en_pwm;
   logic        duty_we;
   logic [3:0]  duty_sel;
   logic [7:0]  duty_wdata;
   logic [7:0]  period_top;
   logic [7:0]  prescale;
   logic [15:0] out;
   logic        period_start;

   int checks = 0;
   int errors = 0;
   int hi [16];
   int ps_cnt;

   pwm_multichannel #(
      .NUM_CH (16),
      .CNT_W  (8),
      .PRE_W  (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_out       (en_out),
      .en_pwm       (en_pwm),
      .duty_we      (duty_we),
      .duty_sel     (duty_sel),
      .duty_wdata   (duty_wdata),
      .period_top   (period_top),
      .prescale     (prescale),
      .out          (out),
      .period_start (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Inputs change only at negedges; the strobe is held for exactly one posedge.
   task automatic wr_duty(input int ch, input int val);
      duty_we    = 1'b1;
      duty_sel   = ch[3:0];
      duty_wdata = val[7:0];
      @(negedge clk);
      duty_we    = 1'b0;
   endtask

   task automatic wait_ps(input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!period_start && (k < budget));
      chk("ps_seen", {31'b0, period_start}, 32'd1);
   endtask

   task automatic measure(input int n);
      for (int c = 0; c < 16; c++) hi[c] = 0;
      ps_cnt = 0;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         for (int c = 0; c < 16; c++) hi[c] += int'(out[c]);
         ps_cnt += int'(period_start);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      en_out     = '0;
      en_pwm     = '0;
      duty_we    = 1'b0;
      duty_sel   = '0;
      duty_wdata = '0;
      period_top = 8'd255;
      prescale   = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_out", {16'b0, out}, 32'd0);
      chk("rst_ps", {31'b0, period_start}, 32'd0);
      chk("rst_cnt", {24'b0, dut.u_timebase.cnt_q}, 32'd0);

      // 128/256 on ch0, ch1 left at duty 0
      rst_n  = 1'b1;
      en_out = '1;
      en_pwm = '1;
      wr_duty(0, 128);
      wait_ps(600);
      @(negedge clk);
      chk("d128_first", {31'b0, out[0]}, 32'd1);
      measure(256);
      chk("d128_high", hi[0], 128);
      chk("d0_low", hi[1], 0);
      chk("p256_ps", ps_cnt, 1);

      // shadow: ch3 runs 32, then 200 and 64 written mid-period
      wr_duty(3, 32);
      wait_ps(600);
      repeat (40) @(negedge clk);
      wr_duty(3, 200);
      wr_duty(3, 64);
      measure(100);
`ifdef PWM_SHADOW_EN
      chk("shadow_hold", hi[3], 0);
`else
      chk("direct_mid", hi[3], 22);
`endif
      wait_ps(600);
      @(negedge clk);
      chk("d64_first", {31'b0, out[3]}, 32'd1);
      measure(256);
      chk("d64_high", hi[3], 64);

      // write coincident with the wrap
      wait_ps(600);
      repeat (255) @(negedge clk);
      wr_duty(3, 16);
      chk("coinc_ps", {31'b0, period_start}, 32'd1);
      @(negedge clk);
      chk("coinc_first", {31'b0, out[3]}, 32'd1);
      measure(256);
      chk("coinc_high", hi[3], 16);

      // top 254, duty 255: 100%
      period_top = 8'd254;
      wr_duty(0, 255);
      wait_ps(600);
      wait_ps(600);
      measure(300);
      chk("full_high", hi[0], 300);
      chk("full_d0", hi[1], 0);
      chk("full_ps", ps_cnt, 1);

      // top 0, duty 1: constant high, wrap every clock
      period_top = 8'd0;
      wr_duty(0, 1);
      wait_ps(600);
      wait_ps(600);
      measure(20);
      chk("top0_high", hi[0], 20);
      chk("top0_ps", ps_cnt, 20);

      // prescale 3, top 9, duty 5: 40-clock period, 20 high
      prescale   = 8'd3;
      period_top = 8'd9;
      wr_duty(0, 5);
      wait_ps(600);
      wait_ps(600);
      measure(40);
      chk("pre_high", hi[0], 20);
      chk("pre_ps", ps_cnt, 1);

      // write latency on ch7 (duty 255 > top 9)
      wr_duty(7, 255);
      chk("lat_1clk", {31'b0, out[7]}, 32'd0);
      @(negedge clk);
`ifdef PWM_SHADOW_EN
      chk("lat_pending", {31'b0, out[7]}, 32'd0);
      wait_ps(600);
      @(negedge clk);
      chk("lat_wrap", {31'b0, out[7]}, 32'd1);
`else
      chk("lat_2clk", {31'b0, out[7]}, 32'd1);
`endif

      // enables on ch5 (duty 0)
      chk("en_base", {31'b0, out[5]}, 32'd0);
      en_pwm[5] = 1'b0;
      @(negedge clk);
      chk("en_static", {31'b0, out[5]}, 32'd1);
      en_out[5] = 1'b0;
      @(negedge clk);
      chk("en_off", {31'b0, out[5]}, 32'd0);

      // reset mid-period with a pending write
      wr_duty(9, 7);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_out", {16'b0, out}, 32'd0);
      chk("mrst_cnt", {24'b0, dut.u_timebase.cnt_q}, 32'd0);
      chk("mrst_ps", {31'b0, period_start}, 32'd0);
      rst_n = 1'b1;
      measure(30);
      chk("rel_ps", ps_cnt, 0);
      chk("rel_ch0", hi[0], 0);
      chk("rel_ch9", hi[9], 0);
      wait_ps(2000);
      measure(40);
      chk("post_ch0", hi[0], 0);
      chk("post_ch7", hi[7], 0);
      chk("post_ch9", hi[9], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
